// File: rtl/tc_pkg.sv
// Shared encodings for the timer/counter: bus register selects, CTRL bit
// positions, MODE values and FSM state codes.
package tc_pkg;

  typedef enum logic [1:0] {
    SEL_CTRL   = 2'd0,
    SEL_PRESET = 2'd1,
    SEL_COUNT  = 2'd2,
    SEL_RSVD   = 2'd3
  } sel_e;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_e;

endpackage

// File: rtl/tc.sv
// Bus-mapped down-counting timer with one-shot and auto-reload modes.
// Register writes take priority: the FSM and counter hold in any WE cycle.
module tc
  import tc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:2] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

  logic [3:0]  r_ctrl;
  logic [31:0] r_preset;
  logic [31:0] r_count;
  logic        r_irq;
  state_e      r_state;

  state_e      w_state_next;
  sel_e        w_sel;
  logic        w_en;
  logic [1:0]  w_mode;
  logic        w_count_last;
  logic        w_load_cnt;
  logic        w_dec_cnt;
  logic        w_set_irq;
  logic        w_clr_irq;
  logic        w_clr_en;
  logic        w_unused_addr;

  assign w_sel         = sel_e'(Addr[3:2]);
  assign w_unused_addr = ^Addr[31:4];
  assign w_en          = r_ctrl[CTRL_EN];
  assign w_mode        = r_ctrl[CTRL_MODE_HI:CTRL_MODE_LO];
  // COUNT of 1 or 0 both end the run; 0 wraps to all-ones on the decrement.
  assign w_count_last  = (r_count <= 32'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (!WE) begin
      case (r_state)
        ST_IDLE: if (w_en) w_state_next = ST_LOAD;
        ST_LOAD: w_state_next = ST_CNT;
        ST_CNT: begin
          if (!w_en)             w_state_next = ST_IDLE;
          else if (w_count_last) w_state_next = ST_INT;
        end
        ST_INT:  w_state_next = ST_IDLE;
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_load_cnt = 1'b0;
    w_dec_cnt  = 1'b0;
    w_set_irq  = 1'b0;
    w_clr_irq  = 1'b0;
    w_clr_en   = 1'b0;
    if (!WE) begin
      case (r_state)
        ST_IDLE: w_clr_irq = w_en;
        ST_LOAD: w_load_cnt = 1'b1;
        ST_CNT: begin
          w_dec_cnt = w_en;
          w_set_irq = w_en & w_count_last;
        end
        ST_INT: begin
          // One-shot keeps the irq flag and disables itself; auto-reload pulses.
          if (w_mode == MODE_ONESHOT) w_clr_en  = 1'b1;
          else                        w_clr_irq = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ctrl   <= 4'd0;
      r_preset <= 32'd0;
      r_count  <= 32'd0;
      r_irq    <= 1'b0;
    end else begin
      if (WE) begin
        case (w_sel)
          SEL_CTRL:   r_ctrl   <= Din[3:0];
          SEL_PRESET: r_preset <= Din;
          default: ;
        endcase
      end
      if (w_load_cnt)     r_count <= r_preset;
      else if (w_dec_cnt) r_count <= r_count - 32'd1;
      if (w_set_irq)      r_irq <= 1'b1;
      else if (w_clr_irq) r_irq <= 1'b0;
      if (w_clr_en)       r_ctrl[CTRL_EN] <= 1'b0;
    end
  end

  always_comb begin
    case (w_sel)
      SEL_CTRL:   Dout = {28'd0, r_ctrl};
      SEL_PRESET: Dout = r_preset;
      SEL_COUNT:  Dout = r_count;
      default:    Dout = 32'd0;
    endcase
  end

  assign IRQ = r_irq & r_ctrl[CTRL_IM];

endmodule

// File: tb/tb_tc.sv
// Directed-vector bench for the timer/counter: reset, one-shot, auto-reload,
// masking, register access, wrap-around and disable-during-count.
module tb_tc;

  logic        clk;
  logic        reset;
  logic [31:2] Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;

  int n_vec;
  int n_err;

  tc dut (
    .clk  (clk),
    .reset(reset),
    .Addr (Addr),
    .WE   (WE),
    .Din  (Din),
    .Dout (Dout),
    .IRQ  (IRQ)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // Caller sits at a negedge; the write lands on the next posedge.
  task automatic bus_write(input logic [1:0] sel, input logic [31:0] d);
    Addr = {28'd0, sel};
    Din  = d;
    WE   = 1'b1;
    @(negedge clk);
    WE   = 1'b0;
  endtask

  task automatic read_chk(input logic [1:0] sel, input string tag, input logic [31:0] exp);
    Addr = {28'd0, sel};
    #1;
    check(tag, Dout, exp);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b0;
    WE    = 1'b0;
    Addr  = '0;
    Din   = '0;
    @(negedge clk);
    do_reset();

    read_chk(2'd0, "rst_ctrl", 32'h0);
    read_chk(2'd1, "rst_preset", 32'h0);
    read_chk(2'd2, "rst_count", 32'h0);
    check("rst_irq", 32'(IRQ), 32'h0);

    // One-shot: PRESET=5, IRQ after 7 cycles and then held.
    bus_write(2'd1, 32'd5);
    bus_write(2'd0, 32'h9);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      read_chk(2'd2, $sformatf("os_cnt_%0d", k), (k < 2) ? 32'd0 : (k <= 7 ? 32'(7 - k) : 32'd0));
      check($sformatf("os_irq_%0d", k), 32'(IRQ), (k >= 7) ? 32'd1 : 32'd0);
    end
    read_chk(2'd0, "os_ctrl", 32'h8);

    // Auto-reload: PRESET=3, one-cycle IRQ every 6 cycles.
    do_reset();
    bus_write(2'd1, 32'd3);
    bus_write(2'd0, 32'hB);
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      check($sformatf("ar_irq_%0d", k), 32'(IRQ), (k == 5 || k == 11) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    read_chk(2'd2, "ar_cnt_mid", 32'd2);

    // Asynchronous reset mid-count.
    reset = 1'b1;
    #1;
    check("arst_irq", 32'(IRQ), 32'h0);
    read_chk(2'd0, "arst_ctrl", 32'h0);
    read_chk(2'd1, "arst_preset", 32'h0);
    read_chk(2'd2, "arst_count", 32'h0);
    read_chk(2'd3, "arst_rsvd", 32'h0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      read_chk(2'd2, $sformatf("arst_idle_cnt_%0d", k), 32'h0);
      check($sformatf("arst_idle_irq_%0d", k), 32'(IRQ), 32'h0);
    end

    // Masked one-shot, then unmask with EN=0.
    do_reset();
    bus_write(2'd1, 32'd2);
    bus_write(2'd0, 32'h1);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check($sformatf("mask_irq_%0d", k), 32'(IRQ), 32'h0);
    end
    read_chk(2'd0, "mask_ctrl", 32'h0);
    bus_write(2'd0, 32'h8);
    check("unmask_irq", 32'(IRQ), 32'h1);

    // Register access.
    do_reset();
    bus_write(2'd2, 32'h1234_5678);
    read_chk(2'd2, "reg_count_ro", 32'h0);
    bus_write(2'd3, 32'hFFFF_FFFF);
    read_chk(2'd3, "reg_rsvd", 32'h0);
    bus_write(2'd1, 32'hDEAD_BEEF);
    read_chk(2'd1, "reg_preset", 32'hDEAD_BEEF);
    bus_write(2'd0, 32'hFFFF_FFFF);
    read_chk(2'd0, "reg_ctrl", 32'h0000_000F);

    // PRESET=0 wraps COUNT to all-ones and fires on the first CNT cycle.
    do_reset();
    bus_write(2'd0, 32'h9);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      read_chk(2'd2, $sformatf("wrap_cnt_%0d", k), (k == 3) ? 32'hFFFF_FFFF : 32'h0);
      check($sformatf("wrap_irq_%0d", k), 32'(IRQ), (k == 3) ? 32'd1 : 32'd0);
    end

    // Disable during count: COUNT freezes, FSM returns to IDLE.
    do_reset();
    bus_write(2'd1, 32'd10);
    bus_write(2'd0, 32'h9);
    for (int k = 1; k <= 4; k++) @(negedge clk);
    read_chk(2'd2, "dis_cnt_before", 32'd8);
    bus_write(2'd0, 32'h8);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      read_chk(2'd2, $sformatf("dis_cnt_%0d", k), 32'd8);
      check($sformatf("dis_irq_%0d", k), 32'(IRQ), 32'h0);
    end
    bus_write(2'd0, 32'h9);
    @(negedge clk);
    @(negedge clk);
    read_chk(2'd2, "dis_reload", 32'd10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
